// File: rtl/order_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | order_pkg                                                                  |
// | Shared widths, side codes, FSM states and book-level opcodes.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package order_pkg;

  localparam int PRICE_W = 8;
  localparam int QTY_W   = 8;

  localparam logic [QTY_W-1:0] QTY_MAX = 8'd255;

  localparam logic SIDE_BUY  = 1'b1;
  localparam logic SIDE_SELL = 1'b0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EVAL  = 3'd1;
  localparam logic [2:0] S_TRADE = 3'd2;
  localparam logic [2:0] S_REST  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [2:0] OP_NONE    = 3'd0;
  localparam logic [2:0] OP_REPLACE = 3'd1;
  localparam logic [2:0] OP_ADD     = 3'd2;
  localparam logic [2:0] OP_CONSUME = 3'd3;
  localparam logic [2:0] OP_CLEAR   = 3'd4;

  typedef struct packed {
    logic               side;
    logic [PRICE_W-1:0] price;
    logic [QTY_W-1:0]   qty;
  } order_t;

  function automatic logic [QTY_W-1:0] qty_min(input logic [QTY_W-1:0] a,
                                               input logic [QTY_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/book_level_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | book_level_reg                                                             |
// | One price level (price/qty/valid) with replace, saturating add and consume.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module book_level_reg
  import order_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         i_op,
  input  logic [PRICE_W-1:0] i_price,
  input  logic [QTY_W-1:0]   i_qty,
  output logic [PRICE_W-1:0] o_price,
  output logic [QTY_W-1:0]   o_qty,
  output logic               o_valid,
  output logic [PRICE_W-1:0] o_nxt_price,
  output logic               o_nxt_valid
);

  logic [PRICE_W-1:0] r_price;
  logic [PRICE_W-1:0] w_price;
  logic [QTY_W-1:0]   r_qty;
  logic [QTY_W-1:0]   w_qty;
  logic               r_valid;
  logic               w_valid;
  logic [QTY_W:0]     w_sum;

  // An emptied level always reads back as price 0 / qty 0.
  always_comb begin
    w_price = r_price;
    w_qty   = r_qty;
    w_valid = r_valid;
    w_sum   = {1'b0, r_qty} + {1'b0, i_qty};
    case (i_op)
      OP_REPLACE: begin
        w_price = i_price;
        w_qty   = i_qty;
        w_valid = 1'b1;
      end
      OP_ADD: begin
        w_qty = (w_sum > {1'b0, QTY_MAX}) ? QTY_MAX : w_sum[QTY_W-1:0];
      end
      OP_CONSUME: begin
        if (i_qty >= r_qty) begin
          w_price = '0;
          w_qty   = '0;
          w_valid = 1'b0;
        end else begin
          w_qty = r_qty - i_qty;
        end
      end
      OP_CLEAR: begin
        w_price = '0;
        w_qty   = '0;
        w_valid = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_price <= '0;
      r_qty   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_price <= w_price;
      r_qty   <= w_qty;
      r_valid <= w_valid;
    end
  end

  assign o_price     = r_price;
  assign o_qty       = r_qty;
  assign o_valid     = r_valid;
  assign o_nxt_price = w_price;
  assign o_nxt_valid = w_valid;

endmodule
`default_nettype wire

// File: rtl/order_match_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | order_match_engine                                                         |
// | Single-level limit-order matcher: best bid/ask, trade stream, spread.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module order_match_engine
  import order_pkg::*;
#(
  parameter int MATCH_HOLD = 4,
  parameter int COUNT_MAX  = 100
)(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               order_valid,
  output logic               order_ready,
  input  logic               order_side,
  input  logic [PRICE_W-1:0] order_price,
  input  logic [QTY_W-1:0]   order_qty,
  input  logic               clear_book,
  output logic [PRICE_W-1:0] trade_price,
  output logic [QTY_W-1:0]   trade_qty,
  output logic               match_signal,
  output logic [PRICE_W-1:0] spread,
  output logic [7:0]         trade_count,
  output logic [PRICE_W-1:0] best_bid,
  output logic [PRICE_W-1:0] best_ask,
  output logic               bid_valid,
  output logic               ask_valid,
  output logic               order_rejected
);

  localparam int              c_hold_w     = $clog2(MATCH_HOLD + 1);
  localparam logic [c_hold_w-1:0] c_match_hold = c_hold_w'(MATCH_HOLD);
  localparam logic [7:0]      c_count_max  = 8'(COUNT_MAX);

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic                r_ready;
  order_t              r_order;
  logic [PRICE_W-1:0]  r_trade_price;
  logic [QTY_W-1:0]    r_trade_qty;
  logic                r_match;
  logic [c_hold_w-1:0] r_hold;
  logic [PRICE_W-1:0]  r_spread;
  logic [7:0]          r_count;
  logic                r_rejected;

  logic [PRICE_W-1:0]  w_bid_price, w_ask_price, w_bid_nxt_price, w_ask_nxt_price;
  logic [QTY_W-1:0]    w_bid_qty, w_ask_qty;
  logic                w_bid_valid, w_ask_valid, w_bid_nxt_valid, w_ask_nxt_valid;
  logic [2:0]          w_bid_op, w_ask_op, w_own_op, w_opp_op;

  logic                w_accept;
  logic                w_is_buy;
  logic                w_opp_valid, w_own_valid;
  logic [PRICE_W-1:0]  w_opp_price, w_own_price;
  logic [QTY_W-1:0]    w_opp_qty;
  logic                w_cross;
  logic [QTY_W-1:0]    w_fill;
  logic [QTY_W-1:0]    w_rem;
  logic                w_better, w_equal, w_zero, w_reject;
  logic [PRICE_W-1:0]  w_spread_nxt;

  assign w_accept = (r_state == S_IDLE) && r_ready && order_valid;

  // Order evaluation against the captured order; only acted on in S_EVAL.
  always_comb begin
    w_is_buy    = (r_order.side == SIDE_BUY);
    w_opp_valid = w_is_buy ? w_ask_valid : w_bid_valid;
    w_opp_price = w_is_buy ? w_ask_price : w_bid_price;
    w_opp_qty   = w_is_buy ? w_ask_qty   : w_bid_qty;
    w_own_valid = w_is_buy ? w_bid_valid : w_ask_valid;
    w_own_price = w_is_buy ? w_bid_price : w_ask_price;
    w_zero      = (r_order.qty == '0);
    w_cross     = w_opp_valid && (w_is_buy ? (r_order.price >= w_opp_price)
                                           : (r_order.price <= w_opp_price));
    w_fill      = w_cross ? qty_min(r_order.qty, w_opp_qty) : '0;
    w_rem       = r_order.qty - w_fill;
    w_better    = !w_own_valid || (w_is_buy ? (r_order.price > w_own_price)
                                            : (r_order.price < w_own_price));
    w_equal     = w_own_valid && (r_order.price == w_own_price);
    w_reject    = w_zero || ((w_rem != '0) && !w_better && !w_equal);
  end

  always_comb begin
    w_own_op = OP_NONE;
    w_opp_op = OP_NONE;
    if (r_state == S_EVAL && !w_zero) begin
      if (w_cross)
        w_opp_op = OP_CONSUME;
      if (w_rem != '0)
        w_own_op = w_better ? OP_REPLACE : (w_equal ? OP_ADD : OP_NONE);
    end
    w_bid_op = w_is_buy ? w_own_op : w_opp_op;
    w_ask_op = w_is_buy ? w_opp_op : w_own_op;
    if (clear_book) begin
      w_bid_op = OP_CLEAR;
      w_ask_op = OP_CLEAR;
    end
  end

  book_level_reg u_bid (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_op        (w_bid_op),
    .i_price     (r_order.price),
    .i_qty       ((w_bid_op == OP_CONSUME) ? w_fill : w_rem),
    .o_price     (w_bid_price),
    .o_qty       (w_bid_qty),
    .o_valid     (w_bid_valid),
    .o_nxt_price (w_bid_nxt_price),
    .o_nxt_valid (w_bid_nxt_valid)
  );

  book_level_reg u_ask (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_op        (w_ask_op),
    .i_price     (r_order.price),
    .i_qty       ((w_ask_op == OP_CONSUME) ? w_fill : w_rem),
    .o_price     (w_ask_price),
    .o_qty       (w_ask_qty),
    .o_valid     (w_ask_valid),
    .o_nxt_price (w_ask_nxt_price),
    .o_nxt_valid (w_ask_nxt_valid)
  );

  // Spread is registered from the next book so it lands with the book update.
  assign w_spread_nxt = (w_bid_nxt_valid && w_ask_nxt_valid) ?
                        (w_ask_nxt_price - w_bid_nxt_price) : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_EVAL;
      S_EVAL:  begin
        if (w_zero)       w_state_nxt = S_IDLE;
        else if (w_cross) w_state_nxt = S_TRADE;
        else              w_state_nxt = S_REST;
      end
      S_TRADE, S_HOLD: w_state_nxt = (r_hold >= c_match_hold) ? S_GAP : S_HOLD;
      S_REST:  w_state_nxt = S_IDLE;
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_ready       <= 1'b0;
      r_order       <= '0;
      r_trade_price <= '0;
      r_trade_qty   <= '0;
      r_match       <= 1'b0;
      r_hold        <= '0;
      r_spread      <= '0;
      r_count       <= '0;
      r_rejected    <= 1'b0;
    end else if (clear_book) begin
      r_state       <= S_IDLE;
      r_ready       <= 1'b0;
      r_order       <= '0;
      r_trade_price <= '0;
      r_trade_qty   <= '0;
      r_match       <= 1'b0;
      r_hold        <= '0;
      r_spread      <= '0;
      r_count       <= '0;
      r_rejected    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ready    <= (w_state_nxt == S_IDLE);
      r_rejected <= (r_state == S_EVAL) && w_reject;
      r_spread   <= w_spread_nxt;
      if (w_accept)
        r_order <= '{side: order_side, price: order_price, qty: order_qty};
      case (r_state)
        S_EVAL: begin
          if (!w_zero && w_cross) begin
            r_trade_price <= w_opp_price;
            r_trade_qty   <= w_fill;
            r_match       <= 1'b1;
            r_hold        <= c_hold_w'(1);
            r_count       <= (r_count >= c_count_max) ? r_count : r_count + 8'd1;
          end
        end
        S_TRADE, S_HOLD: begin
          if (r_hold >= c_match_hold) r_match <= 1'b0;
          else                        r_hold  <= r_hold + c_hold_w'(1);
        end
        default: ;
      endcase
    end
  end

  assign order_ready    = r_ready;
  assign trade_price    = r_trade_price;
  assign trade_qty      = r_trade_qty;
  assign match_signal   = r_match;
  assign spread         = r_spread;
  assign trade_count    = r_count;
  assign best_bid       = w_bid_price;
  assign best_ask       = w_ask_price;
  assign bid_valid      = w_bid_valid;
  assign ask_valid      = w_ask_valid;
  assign order_rejected = r_rejected;

endmodule
`default_nettype wire
